// File: rtl/pc_gen_unit_if.sv
// Request and PC bundle between fetch control (master) and pc_gen_unit (slave).
interface pc_gen_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              xadr_req;
  logic [ADDR_W-1:0] xadr;
  logic              illop_req;
  logic [ADDR_W-1:0] illop;
  logic              jr_req;
  logic [ADDR_W-1:0] jr;
  logic              jt_req;
  logic [ADDR_W-1:0] jt;
  logic              bt_req;
  logic [ADDR_W-1:0] bt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect;
  logic [2:0]        src;
  logic              addr_err;

  modport master (
    output stall,
    output xadr_req, xadr,
    output illop_req, illop,
    output jr_req, jr,
    output jt_req, jt,
    output bt_req, bt,
    input  pc, pc_plus4, redirect, src, addr_err
  );

  modport slave (
    input  stall,
    input  xadr_req, xadr,
    input  illop_req, illop,
    input  jr_req, jr,
    input  jt_req, jt,
    input  bt_req, bt,
    output pc, pc_plus4, redirect, src, addr_err
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: priority redirect arbitration with a one-entry stall buffer.
// Optional target alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] ALIGN_VEC = ADDR_W'(32'h8000_0180)
) (
  input logic          clk,
  input logic          rst,
  pc_gen_unit_if.slave bus
);

  localparam logic [2:0] SRC_PLUS4 = 3'd0;
  localparam logic [2:0] SRC_BT    = 3'd1;
  localparam logic [2:0] SRC_JT    = 3'd2;
  localparam logic [2:0] SRC_JR    = 3'd3;
  localparam logic [2:0] SRC_ILLOP = 3'd4;
  localparam logic [2:0] SRC_XADR  = 3'd5;
  localparam logic [2:0] SRC_ALIGN = 3'd6;

  // Arbitration rank differs from the src code only for ALIGN (between JR and ILLOP).
  function automatic logic [2:0] rank_of(input logic [2:0] code);
    logic [2:0] r;
    case (code)
      SRC_BT:    r = 3'd1;
      SRC_JT:    r = 3'd2;
      SRC_JR:    r = 3'd3;
      SRC_ALIGN: r = 3'd4;
      SRC_ILLOP: r = 3'd5;
      SRC_XADR:  r = 3'd6;
      default:   r = 3'd0;
    endcase
    return r;
  endfunction

`ifdef PC_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] tgt);
    return tgt[1:0] != 2'b00;
  endfunction
`endif

  logic [ADDR_W-1:0] pc_p1;
  logic [2:0]        src_p1;
  logic              redirect_p1;
  logic              pend_v_p1;
  logic [2:0]        pend_src_p1;
  logic [ADDR_W-1:0] pend_tgt_p1;

  logic [ADDR_W-1:0] pc_plus4;
  logic              live_v;
  logic [2:0]        live_src;
  logic [ADDR_W-1:0] live_tgt;
  logic              live_wins;
  logic              cap_wr;

  logic [ADDR_W-1:0] pc_nxt;
  logic [2:0]        src_nxt;
  logic              redirect_nxt;
  logic              pend_v_nxt;
  logic [2:0]        pend_src_nxt;
  logic [ADDR_W-1:0] pend_tgt_nxt;

  assign pc_plus4 = pc_p1 + ADDR_W'(4);

  // Highest live non-exception request; misaligned jumps become ALIGN here so
  // that a buffered entry already carries its final code and rank.
  always_comb begin
    live_v   = 1'b1;
    live_src = SRC_PLUS4;
    live_tgt = '0;
    if (bus.illop_req) begin
      live_src = SRC_ILLOP;
      live_tgt = bus.illop;
    end else if (bus.jr_req) begin
      live_src = SRC_JR;
      live_tgt = bus.jr;
    end else if (bus.jt_req) begin
      live_src = SRC_JT;
      live_tgt = bus.jt;
    end else if (bus.bt_req) begin
      live_src = SRC_BT;
      live_tgt = bus.bt;
    end else begin
      live_v = 1'b0;
    end
`ifdef PC_ALIGN_CHECK_EN
    if (live_v && (live_src != SRC_ILLOP) && is_misaligned(live_tgt)) begin
      live_src = SRC_ALIGN;
      live_tgt = ALIGN_VEC;
    end
`endif
  end

  // Equal rank: live wins on apply, but does not overwrite the buffer on capture.
  assign live_wins = live_v && (!pend_v_p1 || (rank_of(live_src) >= rank_of(pend_src_p1)));
  assign cap_wr    = live_v && (!pend_v_p1 || (rank_of(live_src) >  rank_of(pend_src_p1)));

  always_comb begin
    pc_nxt       = pc_p1;
    src_nxt      = src_p1;
    redirect_nxt = 1'b0;
    pend_v_nxt   = pend_v_p1;
    pend_src_nxt = pend_src_p1;
    pend_tgt_nxt = pend_tgt_p1;
    if (bus.xadr_req) begin
      pc_nxt       = bus.xadr;
      src_nxt      = SRC_XADR;
      redirect_nxt = 1'b1;
      pend_v_nxt   = 1'b0;
    end else if (bus.stall) begin
      if (cap_wr) begin
        pend_v_nxt   = 1'b1;
        pend_src_nxt = live_src;
        pend_tgt_nxt = live_tgt;
      end
    end else if (live_wins) begin
      pc_nxt       = live_tgt;
      src_nxt      = live_src;
      redirect_nxt = 1'b1;
      pend_v_nxt   = 1'b0;
    end else if (pend_v_p1) begin
      pc_nxt       = pend_tgt_p1;
      src_nxt      = pend_src_p1;
      redirect_nxt = 1'b1;
      pend_v_nxt   = 1'b0;
    end else begin
      pc_nxt  = pc_plus4;
      src_nxt = SRC_PLUS4;
    end
  end

  // Stage p1: architectural PC, its source tag and the pending redirect buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p1       <= RESET_VEC;
      src_p1      <= SRC_PLUS4;
      redirect_p1 <= 1'b0;
      pend_v_p1   <= 1'b0;
    end else begin
      pc_p1       <= pc_nxt;
      src_p1      <= src_nxt;
      redirect_p1 <= redirect_nxt;
      pend_v_p1   <= pend_v_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pend_src_p1 <= pend_src_nxt;
    pend_tgt_p1 <= pend_tgt_nxt;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic addr_err_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_p1 <= 1'b0;
    end else begin
      addr_err_p1 <= redirect_nxt && (src_nxt == SRC_ALIGN);
    end
  end

  assign bus.addr_err = addr_err_p1;
`else
  assign bus.addr_err = 1'b0;
`endif

  assign bus.pc       = pc_p1;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.redirect = redirect_p1;
  assign bus.src      = src_p1;

endmodule

// File: doc/pc_gen_unit.md
# pc_gen_unit

Program-counter generation unit for the fetch stage. It owns the PC register and picks the next PC each cycle from sequential increment or one of five redirect sources, using a fixed priority. Redirects that arrive while fetch is stalled are buffered and applied when the stall releases. Exceptions pre-empt stalls.

## Interface
Parameters:
- `ADDR_W`, 32: PC width in bits. Must be ≥ 8.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `ALIGN_VEC`, 32'h8000_0180: target for a misaligned redirect. Used only with `PC_ALIGN_CHECK_EN`.

Ports:
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hold the PC. Applies to everything except `xadr_req`.
- `xadr_req` in 1, `xadr` in ADDR_W: exception redirect.
- `illop_req` in 1, `illop` in ADDR_W: illegal-opcode redirect.
- `jr_req` in 1, `jr` in ADDR_W: register-jump redirect.
- `jt_req` in 1, `jt` in ADDR_W: jump-target redirect.
- `bt_req` in 1, `bt` in ADDR_W: taken-branch redirect.
- `pc` out ADDR_W: current PC (registered).
- `pc_plus4` out ADDR_W: `pc + 4`, combinational, wraps mod 2^ADDR_W.
- `redirect` out 1: registered one-cycle pulse. High when the current `pc` was loaded from a non-sequential source.
- `src` out 3: registered source of the current `pc`. Encoding: 0 PLUS4, 1 BT, 2 JT, 3 JR, 4 ILLOP, 5 XADR, 6 ALIGN.
- `addr_err` out 1: registered one-cycle pulse on a misaligned redirect. Constant 0 without the macro.

## Operation
- Priority: XADR > ILLOP > JR > JT > BT > PLUS4. A numerically larger `src` code wins.
- Pending buffer: one entry holding `pend_v`, `pend_src[2:0]` and `pend_tgt[ADDR_W-1:0]`.
- Effective request each cycle: the highest priority among the live `*_req` inputs and the pending entry.
- When `xadr_req` = 1, regardless of `stall`:
  - `pc` ← `xadr`, `src` = 5, `redirect` = 1.
  - The pending entry is cleared.
- When `stall` = 1 and there is no `xadr_req`:
  - `pc`, `src` and `redirect` hold, except that `redirect` is forced to 0 after its first cycle.
  - Capture into pending: the highest live request is written if `pend_v` = 0 or its priority is greater than `pend_src`. Otherwise the entry is kept.
- When `stall` = 0 and there is no `xadr_req`:
  - If an effective redirect exists, `pc` ← its target, `src` = its code, `redirect` = 1, and the pending entry is cleared.
  - Otherwise `pc` ← `pc_plus4`, `src` = 0, `redirect` = 0.
- A live request and a pending entry of equal priority: the live one wins.
- Request inputs are level-sampled each cycle. The requester holds or drops a request; the block does not acknowledge.

## Timing
- Latency: a request sampled at edge N appears on `pc` after edge N.
- A stalled redirect appears on `pc` after the first edge with `stall` = 0.
- `redirect`, `src` and `addr_err` change on the same edge as `pc`.
- Reset values: `pc` = RESET_VEC, `src` = 0, `redirect` = 0, `addr_err` = 0, `pend_v` = 0. `pc_plus4` = RESET_VEC + 4.
- Reset asserted mid-stall with a pending redirect: the pending entry is discarded and there is no redirect after release.
- Wrap: when `pc` = 2^ADDR_W − 4, the next sequential `pc` is 0.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - When a JR/JT/BT target with `[1:0]` ≠ 0 is applied, `pc` ← ALIGN_VEC, `src` = 6, `redirect` = 1, `addr_err` = 1.
  - ALIGN ranks below ILLOP and above JR in later arbitration.
  - XADR and ILLOP targets are not checked.
- `PC_ALIGN_CHECK_EN` undefined:
  - Targets are loaded unchanged.
  - `addr_err` is tied to 0 and code 6 never appears.

## Test plan
- Reset, then run 3 cycles free → `pc` = 0, 4, 8, 12. Throughout, `src` = 0 and `redirect` = 0.
- `pc` = 0x10. Raise `bt_req` (bt = 0x40) and `jr_req` (jr = 0x80) together → `pc` = 0x80, `src` = 3, one-cycle `redirect`.
- Hold `stall` = 1 for 3 cycles with a one-cycle `bt_req` (0x40), then drop `stall` → `pc` is held throughout, then becomes 0x40 after release with `src` = 1.
- Hold `stall` = 1 with a one-cycle `jt_req` (0x100), then `xadr_req` (0x8000_0180) during the stall → `pc` becomes 0x8000_0180 immediately. After release it goes to 0x8000_0184 (the pending JT is discarded).
- With the macro defined, `jr_req` with jr = 0x42 → `pc` = ALIGN_VEC, `src` = 6, `addr_err` pulse. Without the macro → `pc` = 0x42.
- `pc` = 0xFFFF_FFFC, no requests → next `pc` = 0.
